// File: rtl/round_referee_pkg.sv
// Shared encodings for the round referee and player2: FSM state codes and the
// correct[1:0] feedback codes, so neither side duplicates the other's constants.
package round_referee_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_P1_ENTRY  = 3'd1,
    S_P2_GUESS  = 3'd2,
    S_WIN       = 3'd3,
    S_LOSE      = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CORR_NEUTRAL   = 2'b00,
    CORR_CORRECT   = 2'b01,
    CORR_INCORRECT = 2'b10,
    CORR_IGNORED   = 2'b11
  } correct_e;

  localparam int SECS_W  = 8;
  localparam int LIVES_W = 3;

endpackage

// File: rtl/round_referee_sec_tick_divider.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled, held at 0 otherwise,
// and emits a one-cycle tick on the last count of each second.
module sec_tick_divider #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_d;

  assign tick = enable && (presc_q == LAST);

  always_comb begin
    presc_d = '0;
    if (enable && !tick) begin
      presc_d = presc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/round_referee.sv
// Round referee: sequences P1 entry and P2 guess, runs the countdown, tracks lives and score.
// Define REFEREE_TIME_BONUS_EN to add the remaining seconds to the score on a win.
module round_referee
  import round_referee_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_SECONDS = 30,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start_round,
  input  logic               p1_done,
  input  logic [1:0]         correct,
  input  logic               complete,
  output logic               p1_enable,
  output logic               p2_clear,
  output logic               p2_enable,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [7:0]         secs_left,
  output logic [SCORE_W-1:0] score,
  output logic               round_win,
  output logic               round_lose,
  output logic               game_over
);

  localparam int SUM_W = ((SCORE_W > SECS_W) ? SCORE_W : SECS_W) + 2;

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SECS_W-1:0]    secs_q, secs_d;
  logic                 p2_clear_q, p2_clear_d;
  logic [1:0]           correct_q;
  logic                 complete_q;
  logic                 sec_tick;
  logic [SECS_W-1:0]    win_bonus;

  function automatic logic [SCORE_W-1:0] sat_add_score(
    input logic [SCORE_W-1:0] s,
    input logic [SECS_W-1:0]  bonus
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(s) + SUM_W'(bonus) + SUM_W'(1);
    if (sum > SUM_W'({SCORE_W{1'b1}})) begin
      return {SCORE_W{1'b1}};
    end
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec_lives(input logic [LIVES_W-1:0] l);
    return (l == '0) ? '0 : l - LIVES_W'(1);
  endfunction

`ifdef REFEREE_TIME_BONUS_EN
  assign win_bonus = secs_q;
`else
  assign win_bonus = '0;
`endif

  sec_tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_divider (
    .clock (clock),
    .resetn(resetn),
    .enable(state_q == S_P2_GUESS),
    .tick  (sec_tick)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    secs_d     = secs_q;
    p2_clear_d = 1'b0;

    // The countdown keeps running on the edge that leaves P2_GUESS.
    if (state_q == S_P2_GUESS && sec_tick && secs_q != '0) begin
      secs_d = secs_q - SECS_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_round) state_d = S_P1_ENTRY;
      end
      S_P1_ENTRY: begin
        if (p1_done) begin
          state_d    = S_P2_GUESS;
          secs_d     = SECS_W'(ROUND_SECONDS);
          p2_clear_d = 1'b1;
        end
      end
      S_P2_GUESS: begin
        if (complete_q) begin
          state_d = S_WIN;
        end else if (correct_q == CORR_INCORRECT) begin
          lives_d = sat_dec_lives(lives_q);
          if (lives_q <= LIVES_W'(1)) state_d = S_LOSE;
        end else if (secs_q == '0) begin
          lives_d = sat_dec_lives(lives_q);
          state_d = S_LOSE;
        end
      end
      S_WIN: begin
        score_d = sat_add_score(score_q, win_bonus);
        state_d = S_IDLE;
      end
      S_LOSE: begin
        state_d = (lives_q == '0) ? S_GAME_OVER : S_IDLE;
      end
      S_GAME_OVER: begin
        state_d = S_GAME_OVER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q    <= S_IDLE;
      lives_q    <= LIVES_W'(LIVES);
      score_q    <= '0;
      secs_q     <= '0;
      p2_clear_q <= 1'b0;
      correct_q  <= 2'b00;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      secs_q     <= secs_d;
      p2_clear_q <= p2_clear_d;
      correct_q  <= correct;
      complete_q <= complete;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign secs_left  = secs_q;
  assign score      = score_q;
  assign p2_clear   = p2_clear_q;
  assign p1_enable  = (state_q == S_P1_ENTRY);
  assign p2_enable  = (state_q == S_P2_GUESS);
  assign round_win  = (state_q == S_WIN);
  assign round_lose = (state_q == S_LOSE);
  assign game_over  = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_round_referee.sv
// Self-checking bench for round_referee: directed rounds plus randomized rounds
// checked against a round-level model of lives, countdown and score.
module tb_round_referee;

  localparam int T  = 4;
  localparam int R  = 3;
  localparam int L  = 3;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          start_round = 1'b0;
  logic          p1_done = 1'b0;
  logic [1:0]    correct = 2'b00;
  logic          complete = 1'b0;
  logic          p1_enable, p2_clear, p2_enable;
  logic [2:0]    state, lives;
  logic [7:0]    secs_left;
  logic [SW-1:0] score;
  logic          round_win, round_lose, game_over;

  round_referee #(
    .TICKS_PER_SEC(T),
    .ROUND_SECONDS(R),
    .LIVES        (L),
    .SCORE_W      (SW)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start_round(start_round),
    .p1_done    (p1_done),
    .correct    (correct),
    .complete   (complete),
    .p1_enable  (p1_enable),
    .p2_clear   (p2_clear),
    .p2_enable  (p2_enable),
    .state      (state),
    .lives      (lives),
    .secs_left  (secs_left),
    .score      (score),
    .round_win  (round_win),
    .round_lose (round_lose),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lives = L;
  int m_score = 0;
  bit m_over  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int secs_at(input int n);
    int v;
    v = R - n / T;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    start_round = 1'b0;
    p1_done     = 1'b0;
    complete    = 1'b0;
    correct     = 2'b00;
  endtask

  task automatic do_reset();
    drive_idle();
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    m_lives = L;
    m_score = 0;
    m_over  = 1'b0;
    check_eq("rst_state", state, 0);
    check_eq("rst_lives", lives, L);
    check_eq("rst_score", score, 0);
    check_eq("rst_secs", secs_left, 0);
    check_eq("rst_pulses", {p1_enable, p2_clear, p2_enable, round_win, round_lose, game_over}, 0);
  endtask

  task automatic enter_p2();
    int k;
    check_eq("idle_state", state, 0);
    start_round = 1'b1;
    step();
    start_round = 1'b0;
    check_eq("p1_state", state, 1);
    check_eq("p1_enable", p1_enable, 1);
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      step();
      check_eq("p1_hold", state, 1);
    end
    p1_done = 1'b1;
    step();
    p1_done = 1'b0;
  endtask

  // mode 0 random, 1 no events, 2 complete+strike together, 4 strike then complete, 5 complete at once
  task automatic play_p2(input int mode);
    int lv, n, bonus;
    bit done, c_now, s_now, c_prev, s_prev;
    int codes[3] = '{0, 1, 3};
    lv = m_lives; n = 0; done = 1'b0; c_prev = 1'b0; s_prev = 1'b0;
    while (!done) begin
      check_eq("p2_state", state, 2);
      check_eq("p2_enable", p2_enable, 1);
      check_eq("p2_secs", secs_left, secs_at(n));
      check_eq("p2_lives", lives, lv);
      check_eq("p2_clear", p2_clear, (n == 0));
      case (mode)
        1:       begin c_now = 1'b0;     s_now = 1'b0;     end
        2:       begin c_now = (n == 1); s_now = (n == 1); end
        4:       begin c_now = (n == 1); s_now = (n == 0); end
        5:       begin c_now = (n == 0); s_now = 1'b0;     end
        default: begin
          c_now = ($urandom_range(0, 11) == 0);
          s_now = ($urandom_range(0, 7) == 0);
        end
      endcase
      complete = c_now;
      correct  = s_now ? 2'b10 : 2'(codes[$urandom_range(0, 2)]);
      step();
      if (c_prev) begin
        check_eq("win_state", state, 3);
        check_eq("win_pulse", {round_win, round_lose}, 2'b10);
        check_eq("win_lives", lives, lv);
        check_eq("win_secs", secs_left, secs_at(n + 1));
`ifdef REFEREE_TIME_BONUS_EN
        bonus = secs_at(n + 1);
`else
        bonus = 0;
`endif
        drive_idle();
        step();
        m_score = m_score + 1 + bonus;
        if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
        check_eq("win_exit", state, 0);
        check_eq("win_score", score, m_score);
        check_eq("win_pulse_off", round_win, 0);
        done = 1'b1;
      end else if ((s_prev && lv == 1) || (!s_prev && secs_at(n) == 0)) begin
        if (lv > 0) lv--;
        check_eq("lose_state", state, 4);
        check_eq("lose_pulse", {round_win, round_lose}, 2'b01);
        check_eq("lose_lives", lives, lv);
        drive_idle();
        step();
        check_eq("lose_exit", state, (lv == 0) ? 5 : 0);
        if (lv == 0) begin
          check_eq("go_flag", game_over, 1);
          m_over = 1'b1;
        end
        done = 1'b1;
      end else if (s_prev) begin
        lv--;
      end
      c_prev = c_now;
      s_prev = s_now;
      n++;
      if (!done && n > 40) begin
        check_eq("p2_bound", n, 40);
        done = 1'b1;
      end
    end
    drive_idle();
    m_lives = lv;
  endtask

  task automatic probe_game_over();
    start_round = 1'b1;
    p1_done     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("go_hold", state, 5);
      check_eq("go_p1_enable", p1_enable, 0);
    end
    drive_idle();
  endtask

  initial begin
    do_reset();

    enter_p2(); play_p2(5);
    enter_p2(); play_p2(1);

    do_reset();
    enter_p2(); play_p2(2);

    do_reset();
    for (int r = 0; r < 3; r++) begin
      enter_p2(); play_p2(4);
    end
    probe_game_over();

    do_reset();
    enter_p2(); play_p2(5);
    enter_p2(); play_p2(5);
    enter_p2();
    step();
    step();
    check_eq("mid_state", state, 2);
    do_reset();

    for (int r = 0; r < 30; r++) begin
      if (m_over) begin
        probe_game_over();
        do_reset();
      end else begin
        enter_p2();
        play_p2(0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
